// File: rtl/aexm_stall_ctrl.sv
// AEXM pipeline stall controller.
// Sequences CPU, icache and dcache enables around data-memory operations,
// bounds the number of dcache commands in flight, and keeps a saturating
// count of stalled cycles.
module aexm_stall_ctrl #(
   parameter int unsigned MAX_OUTST      = 2,
   parameter int unsigned POSTED_STORES  = 1,
   parameter int unsigned STARTUP_CYCLES = 1,
   parameter int unsigned PERF_W         = 16
) (
   input  logic                             CLK,
   input  logic                             grst,
   input  logic                             icache_busy,
   input  logic                             dcache_busy,
   input  logic                             dSTRLOD,
   input  logic                             dLOD,
   input  logic                             dSKIP,
   input  logic                             fSTALL,
   input  logic                             dcache_ack,
   input  logic                             perf_clr,
   output logic                             cpu_mode_memop,
   output logic                             cpu_enable,
   output logic                             icache_enable,
   output logic                             dcache_enable,
   output logic [$clog2(MAX_OUTST+1)-1:0]   outstanding,
   output logic [PERF_W-1:0]                stall_cycles,
   output logic                             ack_underflow
);

   localparam int unsigned      OUT_W       = $clog2(MAX_OUTST + 1);
   localparam logic [OUT_W-1:0] OUT_MAX     = OUT_W'(MAX_OUTST);
   localparam logic [7:0]       START_LAST  = 8'(STARTUP_CYCLES - 1);
   localparam logic             STORE_DRAIN = (POSTED_STORES == 0);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_e;

   state_e             state_q;
   logic               memop_q;
   logic               just_issued_q;
   logic               xlod_q;
   logic               xstrlod_q;
   logic               starter_q;
   logic               start_done_q;
   logic [7:0]         start_cnt_q;
   logic [OUT_W-1:0]   outst_q,     outst_d;
   logic [PERF_W-1:0]  stall_q,     stall_d;
   logic               underflow_q, underflow_d;

   logic in_run;
   logic cpu_en;
   logic enter;
   logic issue_ok;
   logic den;
   logic need_drain;
   logic exit_ok;
   logic ien;

   // Pipeline enables and FSM transition conditions; all enables forced low in reset
   always_comb begin
      in_run     = (state_q == RUN);
      cpu_en     = grst & (starter_q | (in_run & ~icache_busy));
      enter      = in_run & cpu_en & (dSTRLOD | fSTALL) & ~dSKIP;
      // loads wait for every earlier command to finish; stores only need a free slot
      issue_ok   = xlod_q ? (outst_q == '0) : (outst_q < OUT_MAX);
      den        = grst & (state_q == ISSUE) & ~dcache_busy & ~just_issued_q & issue_ok;
      need_drain = xlod_q | (xstrlod_q & STORE_DRAIN);
      exit_ok    = (state_q == WAIT) & ~icache_busy & ~dcache_busy & ~just_issued_q
                   & (~need_drain | (outst_q == '0));
      ien        = grst & (starter_q | (in_run ? (cpu_en & ~enter) : exit_ok));
   end

   // Next values for the in-flight counter, underflow flag and stall counter
   always_comb begin
      outst_d     = outst_q;
      underflow_d = underflow_q;
      stall_d     = stall_q;
      if (den && !dcache_ack) begin
         outst_d = outst_q + OUT_W'(1);
      end else if (dcache_ack && !den) begin
         if (outst_q == '0) begin
            underflow_d = 1'b1;
         end else begin
            outst_d = outst_q - OUT_W'(1);
         end
      end
      if (perf_clr) begin
         stall_d = '0;
      end else if (!cpu_en && start_done_q && (stall_q != '1)) begin
         stall_d = stall_q + PERF_W'(1);
      end
   end

   // Memop FSM with registered normal-mode flag
   always_ff @(posedge CLK) begin
      if (!grst) begin
         state_q <= RUN;
         memop_q <= 1'b1;
      end else begin
         case (state_q)
            RUN: begin
               if (enter) begin
                  state_q <= dSTRLOD ? ISSUE : WAIT;
                  memop_q <= 1'b0;
               end
            end
            ISSUE: begin
               if (den) begin
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (exit_ok) begin
                  state_q <= RUN;
                  memop_q <= 1'b1;
               end
            end
            default: begin
               state_q <= RUN;
               memop_q <= 1'b1;
            end
         endcase
      end
   end

   // Execute-stage op type capture, issue history, counters and sticky error
   always_ff @(posedge CLK) begin
      if (!grst) begin
         just_issued_q <= 1'b0;
         xlod_q        <= 1'b0;
         xstrlod_q     <= 1'b0;
         outst_q       <= '0;
         stall_q       <= '0;
         underflow_q   <= 1'b0;
      end else begin
         just_issued_q <= den;
         if (cpu_en) begin
            xlod_q    <= dLOD;
            xstrlod_q <= dSTRLOD;
         end
         outst_q     <= outst_d;
         stall_q     <= stall_d;
         underflow_q <= underflow_d;
      end
   end

   // Post-reset starter pulse, STARTUP_CYCLES long, fired once per reset release
   always_ff @(posedge CLK) begin
      if (!grst) begin
         starter_q    <= 1'b0;
         start_cnt_q  <= '0;
         start_done_q <= 1'b0;
      end else if (starter_q) begin
         if (start_cnt_q == '0) begin
            starter_q    <= 1'b0;
            start_done_q <= 1'b1;
         end else begin
            start_cnt_q <= start_cnt_q - 8'd1;
         end
      end else if (!start_done_q) begin
         starter_q   <= 1'b1;
         start_cnt_q <= START_LAST;
      end
   end

   assign cpu_mode_memop = memop_q;
   assign cpu_enable     = cpu_en;
   assign icache_enable  = ien;
   assign dcache_enable  = den;
   assign outstanding    = outst_q;
   assign stall_cycles   = stall_q;
   assign ack_underflow  = underflow_q;

endmodule

// File: tb/tb_aexm_stall_ctrl.sv
// Directed self-checking bench for aexm_stall_ctrl.
// Inputs change 1 time unit after the rising edge; outputs are checked 2 units later.
module tb_aexm_stall_ctrl;

   logic       CLK = 1'b0;
   logic       grst;
   logic       icache_busy, dcache_busy;
   logic       dSTRLOD, dLOD, dSKIP, fSTALL;
   logic       dcache_ack, perf_clr;
   logic       cpu_mode_memop, cpu_enable, icache_enable, dcache_enable;
   logic [1:0] outstanding;
   logic [3:0] stall_cycles;
   logic       ack_underflow;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   aexm_stall_ctrl #(
      .MAX_OUTST      (2),
      .POSTED_STORES  (1),
      .STARTUP_CYCLES (3),
      .PERF_W         (4)
   ) dut (
      .CLK            (CLK),
      .grst           (grst),
      .icache_busy    (icache_busy),
      .dcache_busy    (dcache_busy),
      .dSTRLOD        (dSTRLOD),
      .dLOD           (dLOD),
      .dSKIP          (dSKIP),
      .fSTALL         (fSTALL),
      .dcache_ack     (dcache_ack),
      .perf_clr       (perf_clr),
      .cpu_mode_memop (cpu_mode_memop),
      .cpu_enable     (cpu_enable),
      .icache_enable  (icache_enable),
      .dcache_enable  (dcache_enable),
      .outstanding    (outstanding),
      .stall_cycles   (stall_cycles),
      .ack_underflow  (ack_underflow)
   );

   always #5 CLK = ~CLK;

   // Row layout: {dSTRLOD, dLOD, dSKIP, fSTALL, dcache_ack, dcache_busy, icache_busy}
   task automatic drive(input logic [6:0] v);
      {dSTRLOD, dLOD, dSKIP, fSTALL, dcache_ack, dcache_busy, icache_busy} = v;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      grst = 1'b0; perf_clr = 1'b0;
      drive(7'b0000001);
      tick(); tick(); #2;
      n_checks++;
      if ({cpu_mode_memop, outstanding, stall_cycles, ack_underflow} !== 8'b1_00_0000_0) begin
         n_fail++;
         $display("FAIL reset_state: got memop=%b out=%0d stall=%0d uf=%b, expected 1 0 0 0",
                  cpu_mode_memop, outstanding, stall_cycles, ack_underflow);
      end
      n_checks++;
      if ({cpu_enable, icache_enable, dcache_enable} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_enables: got %b expected 000", {cpu_enable, icache_enable, dcache_enable});
      end
      tick(); grst = 1'b1; #2;
      n_checks++;
      if (cpu_enable !== 1'b0) begin
         n_fail++;
         $display("FAIL release_pre_edge: cpu_enable got %b expected 0", cpu_enable);
      end
      for (int i = 0; i < 3; i++) begin
         tick(); #2;
         n_checks++;
         if ({cpu_enable, icache_enable} !== 2'b11) begin
            n_fail++;
            $display("FAIL starter_cyc%0d: {cpu_en,ic_en} got %b expected 11", i, {cpu_enable, icache_enable});
         end
      end
      tick(); #2;
      n_checks++;
      if ({cpu_enable, icache_enable, stall_cycles} !== 6'b00_0000) begin
         n_fail++;
         $display("FAIL starter_end: {cpu_en,ic_en,stall} got %b expected 000000",
                  {cpu_enable, icache_enable, stall_cycles});
      end
   endtask

   task automatic test_stall_counter();
      repeat (5) tick();
      #2;
      n_checks++;
      if (stall_cycles !== 4'd5) begin
         n_fail++;
         $display("FAIL stall_count: got %0d expected 5", stall_cycles);
      end
      repeat (12) tick();
      #2;
      n_checks++;
      if (stall_cycles !== 4'd15) begin
         n_fail++;
         $display("FAIL stall_saturate: got %0d expected 15", stall_cycles);
      end
      tick(); perf_clr = 1'b1; #2;
      tick(); perf_clr = 1'b0; #2;
      n_checks++;
      if (stall_cycles !== 4'd0) begin
         n_fail++;
         $display("FAIL perf_clr: got %0d expected 0", stall_cycles);
      end
      tick(); drive(7'b0000000); #2;
      n_checks++;
      if ({cpu_enable, stall_cycles} !== 5'b1_0001) begin
         n_fail++;
         $display("FAIL stall_resume: {cpu_en,stall} got %b expected 10001", {cpu_enable, stall_cycles});
      end
      tick(); #2;
      n_checks++;
      if (stall_cycles !== 4'd1) begin
         n_fail++;
         $display("FAIL stall_hold: got %0d expected 1", stall_cycles);
      end
   endtask

   // Expected row layout: {dcache_enable, icache_enable, cpu_enable, cpu_mode_memop, outstanding}
   task automatic test_load();
      logic [6:0] vin [7] = '{7'b1100000, 7'b0000000, 7'b0000000, 7'b0000000,
                              7'b0000100, 7'b0000000, 7'b0000000};
      logic [5:0] vexp[7] = '{6'b001100, 6'b100000, 6'b000001, 6'b000001,
                              6'b000001, 6'b010000, 6'b011100};
      for (int c = 0; c < 7; c++) begin
         tick(); drive(vin[c]); #2;
         n_checks++;
         if ({dcache_enable, icache_enable, cpu_enable, cpu_mode_memop, outstanding} !== vexp[c]) begin
            n_fail++;
            $display("FAIL load_cyc%0d: got %b expected %b", c,
                     {dcache_enable, icache_enable, cpu_enable, cpu_mode_memop, outstanding}, vexp[c]);
         end
      end
      n_checks++;
      if (stall_cycles !== 4'd6) begin
         n_fail++;
         $display("FAIL load_stall_count: got %0d expected 6", stall_cycles);
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] vin [15] = '{7'b1000000, 7'b0000000, 7'b0000000, 7'b0000000,
                               7'b1000000, 7'b0000000, 7'b0000000, 7'b0000000,
                               7'b1000000, 7'b0000000, 7'b0000100, 7'b0000000,
                               7'b0000000, 7'b0000000, 7'b0000000};
      logic [5:0] vexp[15] = '{6'b001100, 6'b100000, 6'b000001, 6'b010001,
                               6'b001101, 6'b100001, 6'b000010, 6'b010010,
                               6'b001110, 6'b000010, 6'b000010, 6'b100001,
                               6'b000010, 6'b010010, 6'b011110};
      for (int c = 0; c < 15; c++) begin
         tick(); drive(vin[c]); #2;
         n_checks++;
         if ({dcache_enable, icache_enable, cpu_enable, cpu_mode_memop, outstanding} !== vexp[c]) begin
            n_fail++;
            $display("FAIL b2b_cyc%0d: got %b expected %b", c,
                     {dcache_enable, icache_enable, cpu_enable, cpu_mode_memop, outstanding}, vexp[c]);
         end
      end
   endtask

   task automatic test_load_drain();
      logic [6:0] vin [9] = '{7'b1100000, 7'b0000000, 7'b0000100, 7'b0000100,
                              7'b0000000, 7'b0000000, 7'b0000100, 7'b0000000,
                              7'b0000000};
      logic [5:0] vexp[9] = '{6'b001110, 6'b000010, 6'b000010, 6'b000001,
                              6'b100000, 6'b000001, 6'b000001, 6'b010000,
                              6'b011100};
      for (int c = 0; c < 9; c++) begin
         tick(); drive(vin[c]); #2;
         n_checks++;
         if ({dcache_enable, icache_enable, cpu_enable, cpu_mode_memop, outstanding} !== vexp[c]) begin
            n_fail++;
            $display("FAIL drain_cyc%0d: got %b expected %b", c,
                     {dcache_enable, icache_enable, cpu_enable, cpu_mode_memop, outstanding}, vexp[c]);
         end
      end
   endtask

   task automatic test_busy();
      logic [6:0] vin [8] = '{7'b1000000, 7'b0000010, 7'b0000000, 7'b0000000,
                              7'b0000001, 7'b0000000, 7'b0000100, 7'b0000000};
      logic [5:0] vexp[8] = '{6'b001100, 6'b000000, 6'b100000, 6'b000001,
                              6'b000001, 6'b010001, 6'b011101, 6'b011100};
      for (int c = 0; c < 8; c++) begin
         tick(); drive(vin[c]); #2;
         n_checks++;
         if ({dcache_enable, icache_enable, cpu_enable, cpu_mode_memop, outstanding} !== vexp[c]) begin
            n_fail++;
            $display("FAIL busy_cyc%0d: got %b expected %b", c,
                     {dcache_enable, icache_enable, cpu_enable, cpu_mode_memop, outstanding}, vexp[c]);
         end
      end
   endtask

   task automatic test_fstall_skip();
      logic [6:0] vin [6] = '{7'b0001000, 7'b0000000, 7'b1010000, 7'b0101000,
                              7'b0000000, 7'b0000000};
      logic [5:0] vexp[6] = '{6'b001100, 6'b010000, 6'b011100, 6'b001100,
                              6'b010000, 6'b011100};
      for (int c = 0; c < 6; c++) begin
         tick(); drive(vin[c]); #2;
         n_checks++;
         if ({dcache_enable, icache_enable, cpu_enable, cpu_mode_memop, outstanding} !== vexp[c]) begin
            n_fail++;
            $display("FAIL fstall_cyc%0d: got %b expected %b", c,
                     {dcache_enable, icache_enable, cpu_enable, cpu_mode_memop, outstanding}, vexp[c]);
         end
      end
   endtask

   task automatic test_underflow();
      n_checks++;
      if (ack_underflow !== 1'b0) begin
         n_fail++;
         $display("FAIL underflow_clear: got %b expected 0", ack_underflow);
      end
      tick(); drive(7'b0000100); #2;
      tick(); drive(7'b0000000); #2;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if ({ack_underflow, outstanding} !== 3'b1_00) begin
            n_fail++;
            $display("FAIL underflow_cyc%0d: {uf,out} got %b expected 100", i, {ack_underflow, outstanding});
         end
         tick(); #2;
      end
   endtask

   task automatic test_reset_mid_wait();
      logic [6:0] vin [3] = '{7'b1100000, 7'b0000000, 7'b0000000};
      for (int c = 0; c < 3; c++) begin
         tick(); drive(vin[c]); #2;
      end
      n_checks++;
      if ({cpu_mode_memop, outstanding} !== 3'b0_01) begin
         n_fail++;
         $display("FAIL pre_reset_wait: {memop,out} got %b expected 001", {cpu_mode_memop, outstanding});
      end
      tick(); grst = 1'b0; #2;
      n_checks++;
      if ({cpu_enable, icache_enable, dcache_enable} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_in_wait_enables: got %b expected 000", {cpu_enable, icache_enable, dcache_enable});
      end
      tick(); #2;
      n_checks++;
      if ({cpu_mode_memop, outstanding, stall_cycles, ack_underflow,
           cpu_enable, icache_enable, dcache_enable} !== 11'b1_00_0000_0_000) begin
         n_fail++;
         $display("FAIL reset_from_wait: got memop=%b out=%0d stall=%0d uf=%b en=%b expected 1 0 0 0 000",
                  cpu_mode_memop, outstanding, stall_cycles, ack_underflow,
                  {cpu_enable, icache_enable, dcache_enable});
      end
      tick(); grst = 1'b1; #2;
   endtask

   initial begin
      test_reset();
      test_stall_counter();
      test_load();
      test_back_to_back();
      test_load_drain();
      test_busy();
      test_fstall_skip();
      test_underflow();
      test_reset_mid_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
